tx_arbiter_4b: RTL and testbench

- Shares the single 4-bit TX stage between NUM_REQ result producers (ALU lanes), each presenting a 10-bit result plus carry.
- Selects one producer round-robin and forwards its result on the TX stage's res_valid/res_ready handshake.
- Holds that grant until the TX stage reports the full 5-nibble frame sent (tx_done).
- Sits between the ALU lanes and the TX stage; it replaces the direct ALU-to-TX connection.

---
 rtl/tx_arbiter_4b.sv | 153 +++++++++++++++
 tb/tb_tx_arbiter_4b.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/tx_arbiter_4b.sv
// Round-robin arbiter that shares the 4-bit TX stage between NUM_REQ ALU result producers; a grant is held until tx_done.
// Optional WAIT_DONE watchdog enabled by macro TX_ARB_TIMEOUT_EN; res_valid follows the accept cycle by one clock.
module tx_arbiter_4b #(
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ*10-1:0] req_data,
  input  logic [NUM_REQ-1:0]    req_carry,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic [9:0]            res_data,
  output logic                  res_carry,
  output logic                  res_valid,
  input  logic                  res_ready,
  input  logic                  tx_done,
  output logic [1:0]            grant_id,
  output logic                  busy,
  output logic                  timeout_err
);

  if (NUM_REQ < 2 || NUM_REQ > 4 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("tx_arbiter_4b: illegal parameter value");
  end

  typedef enum logic [1:0] {IDLE, OFFER, WAIT_DONE} state_t;

  state_t      state_q, state_d;
  logic [1:0]  last_grant_q, last_grant_d;
  logic [1:0]  grant_id_q, grant_id_d;
  logic [9:0]  hold_data_q, hold_data_d;
  logic        hold_carry_q, hold_carry_d;

`ifdef TX_ARB_TIMEOUT_EN
  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] wait_cnt_q, wait_cnt_d;
  logic        timeout_err_q, timeout_err_d;
`endif

  // Pad the requester vectors to the 4-lane maximum so indexing is width-clean for any NUM_REQ.
  logic [3:0]  valid_ext, carry_ext, win_onehot;
  logic [39:0] data_ext;
  logic [2:0]  cand;
  logic [1:0]  win_idx;
  logic        win_found;
  logic [5:0]  win_off;

  assign valid_ext = 4'(req_valid);
  assign carry_ext = 4'(req_carry);
  assign data_ext  = 40'(req_data);

  // Scan downward so the last hit is the nearest index after last_grant.
  always_comb begin
    cand      = '0;
    win_idx   = '0;
    win_found = 1'b0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = {1'b0, last_grant_q} + 3'(k);
      if (cand >= 3'(NUM_REQ)) cand = cand - 3'(NUM_REQ);
      if (valid_ext[cand[1:0]]) begin
        win_idx   = cand[1:0];
        win_found = 1'b1;
      end
    end
  end

  assign win_off    = {4'd0, win_idx} * 6'd10;
  assign win_onehot = 4'b0001 << win_idx;

  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    grant_id_d    = grant_id_q;
    hold_data_d   = hold_data_q;
    hold_carry_d  = hold_carry_q;
`ifdef TX_ARB_TIMEOUT_EN
    wait_cnt_d    = wait_cnt_q;
    timeout_err_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (win_found) begin
          hold_data_d  = data_ext[win_off +: 10];
          hold_carry_d = carry_ext[win_idx];
          grant_id_d   = win_idx;
          state_d      = OFFER;
        end
      end
      OFFER: begin
        if (res_ready) begin
          state_d = WAIT_DONE;
`ifdef TX_ARB_TIMEOUT_EN
          wait_cnt_d = '0;
`endif
        end
      end
      WAIT_DONE: begin
        if (tx_done) begin
          state_d      = IDLE;
          last_grant_d = grant_id_q;
        end
`ifdef TX_ARB_TIMEOUT_EN
        else if (wait_cnt_q == WAIT_LAST) begin
          state_d       = IDLE;
          last_grant_d  = grant_id_q;
          timeout_err_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 16'd1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      last_grant_q  <= 2'(NUM_REQ - 1);
      grant_id_q    <= '0;
      hold_data_q   <= '0;
      hold_carry_q  <= 1'b0;
`ifdef TX_ARB_TIMEOUT_EN
      wait_cnt_q    <= '0;
      timeout_err_q <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      grant_id_q    <= grant_id_d;
      hold_data_q   <= hold_data_d;
      hold_carry_q  <= hold_carry_d;
`ifdef TX_ARB_TIMEOUT_EN
      wait_cnt_q    <= wait_cnt_d;
      timeout_err_q <= timeout_err_d;
`endif
    end
  end

  assign req_ready = (state_q == IDLE && win_found && !rst) ? NUM_REQ'(win_onehot) : '0;
  assign res_valid = (state_q == OFFER);
  assign res_data  = hold_data_q;
  assign res_carry = hold_carry_q;
  assign grant_id  = grant_id_q;
  assign busy      = (state_q != IDLE);
`ifdef TX_ARB_TIMEOUT_EN
  assign timeout_err = timeout_err_q;
`else
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_tx_arbiter_4b.sv
// Directed bench for tx_arbiter_4b (NUM_REQ=2, TIMEOUT_CYCLES=8); timeout scenario depends on TX_ARB_TIMEOUT_EN.
module tb_tx_arbiter_4b;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [19:0] req_data;
  logic [1:0]  req_carry;
  logic [1:0]  req_ready;
  logic [9:0]  res_data;
  logic        res_carry;
  logic        res_valid;
  logic        res_ready;
  logic        tx_done;
  logic [1:0]  grant_id;
  logic        busy;
  logic        timeout_err;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  tx_arbiter_4b #(.NUM_REQ(2), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_data(req_data), .req_carry(req_carry), .req_ready(req_ready),
    .res_data(res_data), .res_carry(res_carry), .res_valid(res_valid), .res_ready(res_ready),
    .tx_done(tx_done), .grant_id(grant_id), .busy(busy), .timeout_err(timeout_err)
  );

  // Inputs change 1 ns after the rising edge; outputs are sampled at the falling edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #4;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 2'b11; req_data = 20'h0; req_carry = 2'b00; res_ready = 1'b0; tx_done = 1'b0;
    step(); step(); settle();
    checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL rst_res_valid got=%b exp=0", res_valid); end
    checks++; if (req_ready !== 2'b00) begin failures++; $display("FAIL rst_req_ready got=%b exp=00", req_ready); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
    checks++; if (grant_id !== 2'd0) begin failures++; $display("FAIL rst_grant_id got=%0d exp=0", grant_id); end
    checks++; if (res_data !== 10'h000 || res_carry !== 1'b0) begin failures++; $display("FAIL rst_res_data got=%h/%b exp=000/0", res_data, res_carry); end
    checks++; if (timeout_err !== 1'b0) begin failures++; $display("FAIL rst_timeout_err got=%b exp=0", timeout_err); end
    step(); rst = 1'b0; req_valid = 2'b00; settle();
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_seq [4];
    logic       seen;
    exp_seq[0] = 2'd0; exp_seq[1] = 2'd1; exp_seq[2] = 2'd0; exp_seq[3] = 2'd1;
    req_data = {10'h155, 10'h0AA}; req_carry = 2'b10; res_ready = 1'b1;
    for (int g = 0; g < 4; g++) begin
      req_valid = 2'b11;
      seen = 1'b0;
      for (int c = 0; c < 8 && !seen; c++) begin
        step(); settle();
        if (res_valid === 1'b1) seen = 1'b1;
      end
      checks++;
      if (!seen) begin
        failures++; $display("FAIL rr_offer_%0d got=no_res_valid exp=res_valid_within_8", g);
      end else if (grant_id !== exp_seq[g]) begin
        failures++; $display("FAIL rr_grant_%0d got=%0d exp=%0d", g, grant_id, exp_seq[g]);
      end
      step(); step(); step(); tx_done = 1'b1;
      step(); tx_done = 1'b0;
    end
    req_valid = 2'b00; res_ready = 1'b0;
    step(); settle();
  endtask

  task automatic test_single();
    // Spurious tx_done while idle must not start anything.
    step(); tx_done = 1'b1; settle();
    step(); tx_done = 1'b0; settle();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL idle_done_busy got=%b exp=0", busy); end
    step(); req_valid = 2'b01; req_data = {10'h3FF, 10'h2A5}; req_carry = 2'b01; res_ready = 1'b1; settle();
    checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL single_req_ready got=%b exp=01", req_ready); end
    checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL single_c0_res_valid got=%b exp=0", res_valid); end
    step(); req_valid = 2'b00; settle();
    checks++; if (res_valid !== 1'b1) begin failures++; $display("FAIL single_c1_res_valid got=%b exp=1", res_valid); end
    checks++; if (res_data !== 10'h2A5 || res_carry !== 1'b1) begin failures++; $display("FAIL single_c1_data got=%h/%b exp=2a5/1", res_data, res_carry); end
    checks++; if (grant_id !== 2'd0) begin failures++; $display("FAIL single_c1_grant got=%0d exp=0", grant_id); end
    step(); settle();
    checks++; if (res_valid !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL single_c2_wait got=valid%b/busy%b exp=valid0/busy1", res_valid, busy); end
    step(); step(); step();
    step(); tx_done = 1'b1; settle();
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL single_c6_busy got=%b exp=1", busy); end
    step(); tx_done = 1'b0; res_ready = 1'b0; settle();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_c7_busy got=%b exp=0", busy); end
  endtask

  task automatic test_backpressure();
    step(); req_valid = 2'b01; req_data = {10'h000, 10'h2A5}; req_carry = 2'b00; res_ready = 1'b0; settle();
    checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL bp_req_ready got=%b exp=01", req_ready); end
    for (int i = 0; i < 3; i++) begin
      step(); req_valid = 2'b00; req_data[9:0] = 10'h011; tx_done = (i == 1); settle();
      checks++;
      if (res_valid !== 1'b1 || res_data !== 10'h2A5 || req_ready !== 2'b00) begin
        failures++; $display("FAIL bp_hold_%0d got=valid%b/data%h/rdy%b exp=valid1/data2a5/rdy00", i, res_valid, res_data, req_ready);
      end
    end
    step(); tx_done = 1'b0; res_ready = 1'b1; settle();
    checks++; if (res_valid !== 1'b1 || res_data !== 10'h2A5) begin failures++; $display("FAIL bp_c4 got=valid%b/data%h exp=valid1/data2a5", res_valid, res_data); end
    step(); res_ready = 1'b0; settle();
    checks++; if (res_valid !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL bp_after got=valid%b/busy%b exp=valid0/busy1", res_valid, busy); end
    step(); tx_done = 1'b1;
    step(); tx_done = 1'b0; settle();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL bp_done_busy got=%b exp=0", busy); end
  endtask

  task automatic test_reset_mid();
    step(); req_valid = 2'b10; req_data = {10'h3C3, 10'h001}; req_carry = 2'b10; res_ready = 1'b0; settle();
    checks++; if (req_ready !== 2'b10) begin failures++; $display("FAIL rmid_req_ready got=%b exp=10", req_ready); end
    step(); req_valid = 2'b00; settle();
    checks++; if (res_valid !== 1'b1 || grant_id !== 2'd1 || res_data !== 10'h3C3) begin failures++; $display("FAIL rmid_offer got=valid%b/grant%0d/data%h exp=valid1/grant1/data3c3", res_valid, grant_id, res_data); end
    #1 rst = 1'b1;
    #1;
    checks++; if (res_valid !== 1'b0 || req_ready !== 2'b00) begin failures++; $display("FAIL rmid_async got=valid%b/rdy%b exp=valid0/rdy00", res_valid, req_ready); end
    checks++; if (busy !== 1'b0 || grant_id !== 2'd0 || res_data !== 10'h000) begin failures++; $display("FAIL rmid_async_state got=busy%b/grant%0d/data%h exp=busy0/grant0/data000", busy, grant_id, res_data); end
    step(); rst = 1'b0; req_valid = 2'b11; settle();
    checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL rmid_first_grant got=%b exp=01", req_ready); end
    step(); req_valid = 2'b00; res_ready = 1'b1; settle();
    checks++; if (res_valid !== 1'b1 || grant_id !== 2'd0 || res_data !== 10'h001) begin failures++; $display("FAIL rmid_offer0 got=valid%b/grant%0d/data%h exp=valid1/grant0/data001", res_valid, grant_id, res_data); end
    step(); res_ready = 1'b0;
    step(); tx_done = 1'b1;
    step(); tx_done = 1'b0; settle();
  endtask

  task automatic test_coincident_done();
    step(); req_valid = 2'b01; req_data = {10'h2C1, 10'h13E}; res_ready = 1'b1; settle();
    checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL coin_req_ready0 got=%b exp=01", req_ready); end
    step(); req_valid = 2'b10; settle();
    checks++; if (res_valid !== 1'b1 || grant_id !== 2'd0) begin failures++; $display("FAIL coin_offer0 got=valid%b/grant%0d exp=valid1/grant0", res_valid, grant_id); end
    step(); settle();
    checks++; if (busy !== 1'b1 || req_ready !== 2'b00) begin failures++; $display("FAIL coin_wait got=busy%b/rdy%b exp=busy1/rdy00", busy, req_ready); end
    step(); tx_done = 1'b1; settle();
    checks++; if (req_ready !== 2'b00) begin failures++; $display("FAIL coin_no_bypass got=%b exp=00", req_ready); end
    step(); tx_done = 1'b0; settle();
    checks++; if (busy !== 1'b0 || req_ready !== 2'b10) begin failures++; $display("FAIL coin_idle got=busy%b/rdy%b exp=busy0/rdy10", busy, req_ready); end
    step(); req_valid = 2'b00; settle();
    checks++; if (res_valid !== 1'b1 || grant_id !== 2'd1 || res_data !== 10'h2C1) begin failures++; $display("FAIL coin_offer1 got=valid%b/grant%0d/data%h exp=valid1/grant1/data2c1", res_valid, grant_id, res_data); end
    step(); res_ready = 1'b0;
    step(); tx_done = 1'b1;
    step(); tx_done = 1'b0; settle();
  endtask

  task automatic test_timeout();
    step(); req_valid = 2'b01; req_data = {10'h0F0, 10'h10F}; res_ready = 1'b1; settle();
    step(); req_valid = 2'b00; settle();
    checks++; if (res_valid !== 1'b1 || grant_id !== 2'd0) begin failures++; $display("FAIL to_offer got=valid%b/grant%0d exp=valid1/grant0", res_valid, grant_id); end
`ifdef TX_ARB_TIMEOUT_EN
    for (int w = 1; w <= 8; w++) begin
      step(); settle();
      checks++;
      if (timeout_err !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL to_wait_%0d got=err%b/busy%b exp=err0/busy1", w, timeout_err, busy); end
    end
    step(); req_valid = 2'b11; settle();
    checks++; if (timeout_err !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL to_pulse got=err%b/busy%b exp=err1/busy0", timeout_err, busy); end
    checks++; if (req_ready !== 2'b10) begin failures++; $display("FAIL to_next_rdy got=%b exp=10", req_ready); end
    step(); req_valid = 2'b00; settle();
    checks++; if (timeout_err !== 1'b0 || grant_id !== 2'd1 || res_valid !== 1'b1) begin failures++; $display("FAIL to_after got=err%b/grant%0d/valid%b exp=err0/grant1/valid1", timeout_err, grant_id, res_valid); end
`else
    for (int w = 1; w <= 20; w++) begin
      step(); settle();
      checks++;
      if (timeout_err !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL nto_wait_%0d got=err%b/busy%b exp=err0/busy1", w, timeout_err, busy); end
    end
`endif
    step(); res_ready = 1'b0;
    step(); tx_done = 1'b1;
    step(); tx_done = 1'b0; settle();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL to_end_busy got=%b exp=0", busy); end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single();
    test_backpressure();
    test_reset_mid();
    test_coincident_done();
    test_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
